serial_out_scheduler: RTL
=========================

Name: serial_out_scheduler

Overview:
- Round-robin scheduler that shares one diff_freq_serial_out instance among NUM_CH requesters.
- Each requester presents a data byte, a frequency select and an idle mode.
- The scheduler picks a winner, latches its settings, pulses the serializer start, waits for the done tick (with a watchdog), then acks the requester and enforces an inter-packet gap.
- Sits between channel-level producers and the serializer; the serializer's port names are mirrored on the o_* side.

Parameters:
- NUM_CH, 4: number of requesters.
- CH_BIT, 2: width of the channel index; must satisfy 2**CH_BIT >= NUM_CH.
- DATA_BIT, 8: packet width; must match the serializer.
- GAP_CYCLES, 4: idle cycles forced between packets; 0 allowed.
- TIMEOUT, 1024: maximum WAIT cycles before abort.
- TO_BIT, 11: watchdog counter width; must satisfy 2**TO_BIT > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  NUM_CH  level request per channel; held until o_ack
- i_data  in  NUM_CH*DATA_BIT  channel c at bits [c*DATA_BIT +: DATA_BIT]
- i_sel_freq  in  NUM_CH  per-channel frequency select (1 = high)
- i_idle_mode  in  2*NUM_CH  per-channel idle mode at bits [2c +: 2]
- i_abort  in  1  software abort of the current packet
- i_done_tick  in  1  from serializer o_done_tick
- o_start  out  1  to serializer i_start
- o_stop  out  1  to serializer i_stop
- o_sel_freq  out  1  to serializer i_sel_freq
- o_idle_mode  out  2  to serializer i_idle_mode
- o_data  out  DATA_BIT  to serializer i_data
- o_ack  out  NUM_CH  one-cycle completion pulse, one-hot
- o_err  out  1  one-cycle pulse, coincident with o_ack, when the packet was aborted or timed out
- o_busy  out  1  high in every state except IDLE
- o_cur_ch  out  CH_BIT  index of the last granted channel

Behaviour:
- Reset: every output is 0, state is IDLE, round-robin pointer is 0, watchdog is 0. Reset in any state takes effect on the next edge and suppresses any pending ack.
- All outputs are registered.
- States: IDLE, START, WAIT, ACK, GAP.
- IDLE:
  - If any i_req is set, the winner is the first requesting channel at or after the pointer, searching upward and wrapping.
  - On that edge: latch o_data, o_sel_freq, o_idle_mode and o_cur_ch; move the pointer to winner+1 (wrapping at NUM_CH); go to START.
- START: o_start=1 for exactly one cycle; watchdog cleared; go to WAIT.
- WAIT:
  - The watchdog increments each cycle.
  - i_done_tick=1: go to ACK with err=0.
  - i_abort=1, or watchdog reaches TIMEOUT: o_stop=1 for one cycle; go to ACK with err=1.
  - If i_done_tick and i_abort are high in the same cycle, done wins: no stop, err=0.
- ACK:
  - o_ack[o_cur_ch]=1 and o_err=err for one cycle.
  - If o_idle_mode==2'b11 (repeat) and err=0, also pulse o_stop this cycle so the serializer halts before the next grant.
  - Then go to GAP if GAP_CYCLES>0, otherwise IDLE.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Requests are not sampled during GAP.
- Minimum issue interval: start to next start is 4 + GAP_CYCLES cycles when the serializer completes immediately.
- o_data, o_sel_freq and o_idle_mode stay stable from START until the next grant. Later changes on the i_* inputs for the granted channel are ignored.
- If i_req drops mid-transfer, the transfer still completes and the ack is still issued.
- A channel holding i_req after its ack competes again at the next IDLE; round-robin prevents starvation.
- i_done_tick outside WAIT is ignored.
- i_abort outside WAIT is ignored.

Test Plan:
- Single requester: ch0 requests 8'h55, high speed, idle low. Required: o_start one cycle later, o_data=8'h55, o_sel_freq=1; o_ack=4'b0001 exactly one cycle after the done tick; o_err=0; o_busy low after the GAP.
- Round robin: ch0..ch3 all hold requests with data 8'hA0..8'hA3. Required grant order is 0,1,2,3,0 with o_data A0,A1,A2,A3,A0; each start is at least 4+GAP_CYCLES cycles apart.
- Timeout: TIMEOUT=16, serializer done is tied off, ch2 requests. Required: o_stop pulse 16 cycles after the start, then o_ack=4'b0100 with o_err=1 on the following cycle.
- Abort vs done: ch1 requests; in WAIT drive i_abort on a cycle with no done tick, and separately drive i_abort and i_done_tick together. Required: the first case gives o_stop and o_err=1; the coincident case gives no o_stop and o_err=0.
- Repeat mode: ch3 requests with idle mode 2'b11, low speed. Required: o_stop and o_ack=4'b1000 in the same cycle, one cycle after the first done tick.
- Reset mid-WAIT: assert rst for one cycle during a transfer. Required: all outputs 0 on the next cycle, no ack issued, pointer back to 0, so the next grant goes to the lowest requesting channel.

Source files
------------

// File: rtl/serial_out_scheduler.sv
// serial_out_scheduler
// Round-robin arbiter that time-shares one diff_freq_serial_out serializer
// between NUM_CH requesters. A granted channel's settings are latched and
// held on the o_* side until the next grant. The scheduler then pulses start,
// waits for done (guarded by a watchdog and a software abort), acks the
// channel and inserts an inter-packet gap.
module serial_out_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int CH_BIT     = 2,
    parameter int DATA_BIT   = 8,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1024,
    parameter int TO_BIT     = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          i_req,
    input  logic [NUM_CH*DATA_BIT-1:0] i_data,
    input  logic [NUM_CH-1:0]          i_sel_freq,
    input  logic [2*NUM_CH-1:0]        i_idle_mode,
    input  logic                       i_abort,
    input  logic                       i_done_tick,
    output logic                       o_start,
    output logic                       o_stop,
    output logic                       o_sel_freq,
    output logic [1:0]                 o_idle_mode,
    output logic [DATA_BIT-1:0]        o_data,
    output logic [NUM_CH-1:0]          o_ack,
    output logic                       o_err,
    output logic                       o_busy,
    output logic [CH_BIT-1:0]          o_cur_ch
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TO_BIT-1:0] TO_VAL    = TO_BIT'(TIMEOUT);
    localparam logic [CH_BIT:0]   NUM_CH_W  = (CH_BIT+1)'(NUM_CH);
    localparam logic [CH_BIT-1:0] LAST_CH   = CH_BIT'(NUM_CH - 1);
    localparam state_t            AFTER_ACK = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    state_t                state_q, state_d;
    logic [CH_BIT-1:0]     ptr_q, ptr_d;
    logic [TO_BIT-1:0]     wd_q, wd_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  err_q, err_d;
    logic                  start_q, start_d;
    logic                  stop_q, stop_d;
    logic                  sel_q, sel_d;
    logic [1:0]            idle_q, idle_d;
    logic [DATA_BIT-1:0]   data_q, data_d;
    logic [NUM_CH-1:0]     ack_q, ack_d;
    logic                  oerr_q, oerr_d;
    logic                  busy_q, busy_d;
    logic [CH_BIT-1:0]     ch_q, ch_d;

    // Per-channel views of the packed inputs, plus the request vector
    // rotated so that position 0 is the channel the pointer names.
    logic [CH_BIT-1:0]     cand    [NUM_CH];
    logic [DATA_BIT-1:0]   data_ch [NUM_CH];
    logic [1:0]            idle_ch [NUM_CH];
    logic [NUM_CH-1:0]     req_rot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CH_BIT:0] sum;
            assign sum         = {1'b0, ptr_q} + (CH_BIT+1)'(gi);
            // ptr and gi are both below NUM_CH, so one subtraction wraps
            assign cand[gi]    = (sum >= NUM_CH_W) ? CH_BIT'(sum - NUM_CH_W) : sum[CH_BIT-1:0];
            assign req_rot[gi] = i_req[cand[gi]];
            assign data_ch[gi] = i_data[gi*DATA_BIT +: DATA_BIT];
            assign idle_ch[gi] = i_idle_mode[2*gi +: 2];
        end
    endgenerate

    logic [CH_BIT-1:0] win;
    logic              win_vld;

    // Round-robin pick: first requester at or after the pointer.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win     = cand[i];
                win_vld = 1'b1;
            end
        end
    end

    logic [NUM_CH-1:0] ack_vec;

    // One-hot of the currently granted channel.
    always_comb begin
        ack_vec        = '0;
        ack_vec[ch_q]  = 1'b1;
    end

    logic [TO_BIT-1:0] wd_inc;
    assign wd_inc = wd_q + TO_BIT'(1);

    // Next-state and next-output computation for the scheduler FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        err_d   = err_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        ack_d   = '0;
        oerr_d  = 1'b0;
        sel_d   = sel_q;
        idle_d  = idle_q;
        data_d  = data_q;
        ch_d    = ch_q;

        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    data_d  = data_ch[win];
                    sel_d   = i_sel_freq[win];
                    idle_d  = idle_ch[win];
                    ch_d    = win;
                    ptr_d   = (win == LAST_CH) ? '0 : win + CH_BIT'(1);
                    start_d = 1'b1;
                    wd_d    = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                // The watchdog measures cycles since the start pulse.
                wd_d    = wd_inc;
                err_d   = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_inc;
                if (i_done_tick) begin
                    // Done beats a coincident abort or timeout.
                    err_d   = 1'b0;
                    ack_d   = ack_vec;
                    stop_d  = (idle_q == 2'b11);
                    state_d = S_ACK;
                end else if (i_abort || (wd_inc == TO_VAL)) begin
                    // Stop first; the error ack follows one cycle later.
                    err_d   = 1'b1;
                    stop_d  = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (err_q) begin
                    ack_d  = ack_vec;
                    oerr_d = 1'b1;
                end
                gap_d   = '0;
                state_d = AFTER_ACK;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, all cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            wd_q    <= '0;
            gap_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            sel_q   <= 1'b0;
            idle_q  <= 2'b00;
            data_q  <= '0;
            ack_q   <= '0;
            oerr_q  <= 1'b0;
            busy_q  <= 1'b0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            sel_q   <= sel_d;
            idle_q  <= idle_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            oerr_q  <= oerr_d;
            busy_q  <= busy_d;
            ch_q    <= ch_d;
        end
    end

    assign o_start     = start_q;
    assign o_stop      = stop_q;
    assign o_sel_freq  = sel_q;
    assign o_idle_mode = idle_q;
    assign o_data      = data_q;
    assign o_ack       = ack_q;
    assign o_err       = oerr_q;
    assign o_busy      = busy_q;
    assign o_cur_ch    = ch_q;

endmodule
